// File: rtl/a09_cpu.sv
// a09_cpu: multi-cycle 16-bit register CPU (PC, 8x16 register file, unified memory, output port).
// Define MUL_EN to decode opcode B as multiply; otherwise it executes as NOP.
module a09_cpu #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned WordSize  = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  output logic                 Ready,
  output logic                 Halt,
  output logic [DataWidth-1:0] OutReg
);

  localparam int unsigned Depth    = 2 ** AddrWidth;
  localparam int unsigned RegCount = 8;

  localparam logic [3:0] OpHlt = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpLdi = 4'h4;
  localparam logic [3:0] OpLd  = 4'h5;
  localparam logic [3:0] OpSt  = 4'h6;
  localparam logic [3:0] OpJmp = 4'h7;
  localparam logic [3:0] OpBz  = 4'h8;
  localparam logic [3:0] OpBnz = 4'h9;
  localparam logic [3:0] OpOut = 4'hA;
`ifdef MUL_EN
  localparam logic [3:0] OpMul = 4'hB;
`endif

  typedef enum logic [3:0] {
    S_Reset,
    S_Ready,
    S_FetchPCtoMEM,
    S_FetchMEMtoIR,
    S_Decode,
    S_Execute,
    S_MemWait,
    S_Halt,
    S_Idle
  } state_e;

  state_e                 state_q;
  logic [AddrWidth-1:0]   pc_q;
  logic [AddrWidth-1:0]   mar_q;
  logic [DataWidth-1:0]   ir_q;
  logic [DataWidth-1:0]   a_q;
  logic [DataWidth-1:0]   b_q;
  logic                   z_q;
  logic [DataWidth-1:0]   out_port_q;
  logic                   ready_q;
  logic                   halt_q;
  logic [DataWidth-1:0]   rf_q  [RegCount];
  logic [DataWidth-1:0]   mem_q [Depth];

  logic [3:0]             op;
  logic [2:0]             rd;
  logic [2:0]             ra;
  logic [2:0]             rb;
  logic [7:0]             imm8;
  logic [DataWidth-1:0]   mem_rdata_c;
  logic                   mem_we_c;
  logic [AddrWidth-1:0]   mem_addr_c;
  logic [DataWidth-1:0]   wb_data_d;
  logic                   wb_en_c;
  logic                   z_upd_c;

  assign op   = ir_q[15:12];
  assign rd   = ir_q[11:9];
  assign ra   = ir_q[8:6];
  assign rb   = ir_q[5:3];
  assign imm8 = ir_q[7:0];

  assign Ready  = ready_q;
  assign Halt   = halt_q;
  assign OutReg = out_port_q;

  // Synchronous read through the registered address; data lands one cycle after mar_q loads.
  assign mem_rdata_c = mem_q[mar_q];
  assign mem_addr_c  = AddrWidth'(a_q[7:0]);
  assign mem_we_c    = Reset && (state_q == S_Execute) && (op == OpSt);

  // Execute-stage result for register-writing opcodes; operands were latched in decode.
  always_comb begin
    wb_data_d = '0;
    wb_en_c   = 1'b0;
    z_upd_c   = 1'b0;
    case (op)
      OpAdd: begin
        wb_data_d = a_q + b_q;
        wb_en_c   = 1'b1;
        z_upd_c   = 1'b1;
      end
      OpSub: begin
        wb_data_d = a_q - b_q;
        wb_en_c   = 1'b1;
        z_upd_c   = 1'b1;
      end
      OpLdi: begin
        wb_data_d = DataWidth'(imm8);
        wb_en_c   = 1'b1;
      end
`ifdef MUL_EN
      OpMul: begin
        wb_data_d = a_q * b_q;
        wb_en_c   = 1'b1;
        z_upd_c   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (mem_we_c) begin
      mem_q[mem_addr_c] <= b_q;
    end
  end

  // Microsequencer: reset has priority, so an in-flight instruction never retires.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= S_Reset;
      pc_q       <= '0;
      ir_q       <= '0;
      z_q        <= 1'b0;
      out_port_q <= '0;
      ready_q    <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      halt_q <= 1'b0;
      case (state_q)
        S_Reset: begin
          state_q <= S_Ready;
          ready_q <= 1'b1;
        end
        S_Ready: state_q <= S_FetchPCtoMEM;
        S_FetchPCtoMEM: begin
          mar_q   <= pc_q;
          state_q <= S_FetchMEMtoIR;
        end
        S_FetchMEMtoIR: begin
          ir_q    <= mem_rdata_c;
          pc_q    <= pc_q + AddrWidth'(WordSize);
          state_q <= S_Decode;
        end
        S_Decode: begin
          a_q     <= rf_q[ra];
          b_q     <= rf_q[rb];
          state_q <= S_Execute;
        end
        S_Execute: begin
          state_q <= S_FetchPCtoMEM;
          if (wb_en_c) rf_q[rd] <= wb_data_d;
          if (z_upd_c) z_q <= (wb_data_d == '0);
          case (op)
            OpHlt: begin
              state_q <= S_Halt;
              halt_q  <= 1'b1;
            end
            OpLd: begin
              mar_q   <= mem_addr_c;
              state_q <= S_MemWait;
            end
            OpJmp: pc_q <= AddrWidth'(imm8);
            OpBz:  if (z_q)  pc_q <= AddrWidth'(imm8);
            OpBnz: if (!z_q) pc_q <= AddrWidth'(imm8);
            OpOut: out_port_q <= a_q;
            default: ;
          endcase
        end
        S_MemWait: begin
          rf_q[rd] <= mem_rdata_c;
          state_q  <= S_FetchPCtoMEM;
        end
        S_Halt: state_q <= S_Idle;
        S_Idle: ;
        default: begin
          state_q <= S_Reset;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a09_cpu.sv
// Testbench for a09_cpu: places small programs in the unified memory, runs each to HLT
// and scores the halt-time state (OutReg, Z, a register, PC, cycle count) against expectations.
module tb_a09_cpu;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  localparam int OP_HLT = 1;
  localparam int OP_ADD = 2;
  localparam int OP_SUB = 3;
  localparam int OP_LDI = 4;
  localparam int OP_LD  = 5;
  localparam int OP_ST  = 6;
  localparam int OP_JMP = 7;
  localparam int OP_BZ  = 8;
  localparam int OP_BNZ = 9;
  localparam int OP_OUT = 10;
  localparam int OP_MUL = 11;
  localparam int OP_C   = 12;

  localparam int HALT_BUDGET = 400;
  localparam int IDLE_CYCLES = 50;

  logic          Clk   = 1'b0;
  logic          Reset = 1'b0;
  logic          Ready;
  logic          Halt;
  logic [DW-1:0] OutReg;

  a09_cpu #(
    .DataWidth(DW),
    .AddrWidth(AW),
    .WordSize (1)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Ready (Ready),
    .Halt  (Halt),
    .OutReg(OutReg)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Posedges since reset release; equals the count at the edge that raises Halt.
  always @(posedge Clk) begin
    if (!Reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    string         name;
    logic [DW-1:0] out;
    logic          z;
    int            rd;
    logic [DW-1:0] rv;
    logic [AW-1:0] pc;
    int            cycles;
  } exp_t;

  typedef struct {
    string         name;
    int            op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic          z;
  } vec_t;

  exp_t          sb [$];
  logic [DW-1:0] img [DEPTH];

  function automatic logic [DW-1:0] enc_r(input int op, input int rd, input int ra, input int rb);
    return {4'(op), 3'(rd), 3'(ra), 3'(rb), 3'b000};
  endfunction

  function automatic logic [DW-1:0] enc_i(input int op, input int rd, input int imm);
    return {4'(op), 3'(rd), 1'b0, 8'(imm)};
  endfunction

  function automatic exp_t mk_exp(input string n, input logic [DW-1:0] out, input logic z,
                                  input int rd, input logic [DW-1:0] rv, input logic [AW-1:0] pc,
                                  input int cycles);
    exp_t e;
    e.name = n; e.out = out; e.z = z; e.rd = rd; e.rv = rv; e.pc = pc; e.cycles = cycles;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < DEPTH; i++) img[i] = '0;
  endtask

  task automatic load_img();
    for (int i = 0; i < DEPTH; i++) dut.mem_q[i] <= img[i];
  endtask

  // Reset, load the image, release, then score the state at the Halt pulse and during idle.
  task automatic run_prog(input exp_t e);
    exp_t got;
    int   bad;
    bit   found;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    load_img();
    @(negedge Clk);
    sb.push_back(e);
    Reset = 1'b1;
    found = 1'b0;
    for (int n = 0; n < HALT_BUDGET; n++) begin
      @(negedge Clk);
      if (Halt) begin
        found = 1'b1;
        break;
      end
    end
    chk({e.name, "/halted"}, 32'(found), 32'd1);
    if (!found) begin
      sb.delete();
    end else begin
      got = sb.pop_front();
      chk({got.name, "/out"},    32'(OutReg),             32'(got.out));
      chk({got.name, "/z"},      32'(dut.z_q),            32'(got.z));
      chk({got.name, "/reg"},    32'(dut.rf_q[got.rd]),   32'(got.rv));
      chk({got.name, "/pc"},     32'(dut.pc_q),           32'(got.pc));
      chk({got.name, "/cycles"}, 32'(cyc),                32'(got.cycles));
      @(negedge Clk);
      chk({got.name, "/halt_one_cycle"}, 32'(Halt), 32'd0);
      bad = 0;
      repeat (IDLE_CYCLES) begin
        @(negedge Clk);
        if (Halt || !Ready || dut.pc_q != got.pc || OutReg != got.out) bad++;
      end
      chk({got.name, "/idle_stable"}, 32'(bad), 32'd0);
    end
  endtask

  initial begin
    vec_t vt [$];

    // Reset phase: hold low ~300 ns with the add program loaded
    clear_img();
    img[0] = enc_i(OP_LDI, 1, 5);
    img[1] = enc_i(OP_LDI, 2, 3);
    img[2] = enc_r(OP_ADD, 3, 1, 2);
    img[3] = enc_r(OP_OUT, 0, 3, 0);
    img[4] = enc_r(OP_HLT, 0, 0, 0);
    Reset = 1'b0;
    @(negedge Clk);
    load_img();
    repeat (29) @(negedge Clk);
    chk("rst/ready", 32'(Ready), 32'd0);
    chk("rst/halt", 32'(Halt), 32'd0);
    chk("rst/outreg", 32'(OutReg), 32'd0);
    chk("rst/pc", 32'(dut.pc_q), 32'd0);
    chk("rst/mem0_loaded", 32'(dut.mem_q[0] != '0), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst/ready_after_release", 32'(Ready), 32'd1);
    chk("rst/pc_after_release", 32'(dut.pc_q), 32'd0);

    run_prog(mk_exp("add_rom", 16'h0008, 1'b0, 3, 16'h0008, 8'd5, 22));

    // ALU table: r3 preset to 0x77 so NOP-class opcodes leave a known value
    vt.push_back(vec_t'{"add_5_3",    OP_ADD, 16'h0005, 16'h0003, 16'h0008, 1'b0});
    vt.push_back(vec_t'{"sub_5_5",    OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1});
    vt.push_back(vec_t'{"sub_3_5",    OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0});
    vt.push_back(vec_t'{"add_carry",  OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1});
    vt.push_back(vec_t'{"add_msb",    OP_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1});
    vt.push_back(vec_t'{"sub_borrow", OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0});
    vt.push_back(vec_t'{"add_mix",    OP_ADD, 16'h1234, 16'h4321, 16'h5555, 1'b0});
    vt.push_back(vec_t'{"op_c_nop",   OP_C,   16'h1111, 16'h2222, 16'h0077, 1'b0});
`ifdef MUL_EN
    vt.push_back(vec_t'{"mul_7_6",    OP_MUL, 16'h0007, 16'h0006, 16'h002A, 1'b0});
    vt.push_back(vec_t'{"mul_wrap0",  OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1});
    vt.push_back(vec_t'{"mul_ffff",   OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0});
`else
    vt.push_back(vec_t'{"mul_as_nop", OP_MUL, 16'h0007, 16'h0006, 16'h0077, 1'b0});
`endif
    foreach (vt[i]) begin
      clear_img();
      img[0]    = enc_i(OP_LDI, 3, 'h77);
      img[1]    = enc_i(OP_LDI, 5, 'h40);
      img[2]    = enc_i(OP_LDI, 6, 'h41);
      img[3]    = enc_r(OP_LD, 1, 5, 0);
      img[4]    = enc_r(OP_LD, 2, 6, 0);
      img[5]    = enc_r(vt[i].op, 3, 1, 2);
      img[6]    = enc_r(OP_OUT, 0, 3, 0);
      img[7]    = enc_r(OP_HLT, 0, 0, 0);
      img['h40] = vt[i].a;
      img['h41] = vt[i].b;
      run_prog(mk_exp(vt[i].name, vt[i].res, vt[i].z, 3, vt[i].res, 8'd8, 36));
    end

    // BZ taken after SUB r1-r1
    clear_img();
    img[0]    = enc_i(OP_LDI, 1, 5);
    img[1]    = enc_r(OP_SUB, 3, 1, 1);
    img[2]    = enc_i(OP_BZ, 0, 'h10);
    img[3]    = enc_i(OP_LDI, 7, 1);
    img[4]    = enc_r(OP_OUT, 0, 7, 0);
    img[5]    = enc_r(OP_HLT, 0, 0, 0);
    img['h10] = enc_i(OP_LDI, 7, 2);
    img['h11] = enc_r(OP_OUT, 0, 7, 0);
    img['h12] = enc_r(OP_HLT, 0, 0, 0);
    run_prog(mk_exp("bz_taken", 16'h0002, 1'b1, 3, 16'h0000, 8'h13, 26));

    // BZ not taken after SUB 3-5
    clear_img();
    img[0]    = enc_i(OP_LDI, 1, 3);
    img[1]    = enc_i(OP_LDI, 2, 5);
    img[2]    = enc_r(OP_SUB, 3, 1, 2);
    img[3]    = enc_i(OP_BZ, 0, 'h10);
    img[4]    = enc_r(OP_OUT, 0, 3, 0);
    img[5]    = enc_r(OP_HLT, 0, 0, 0);
    img['h10] = enc_i(OP_LDI, 7, 2);
    img['h11] = enc_r(OP_OUT, 0, 7, 0);
    img['h12] = enc_r(OP_HLT, 0, 0, 0);
    run_prog(mk_exp("bz_not_taken", 16'hFFFE, 1'b0, 3, 16'hFFFE, 8'd6, 26));

    // Store then load back through a clobbered register
    clear_img();
    img[0]    = enc_i(OP_LDI, 5, 'h30);
    img[1]    = enc_r(OP_LD, 2, 5, 0);
    img[2]    = enc_i(OP_LDI, 6, 'h20);
    img[3]    = enc_r(OP_ST, 0, 6, 2);
    img[4]    = enc_i(OP_LDI, 2, 0);
    img[5]    = enc_r(OP_LD, 4, 6, 0);
    img[6]    = enc_r(OP_OUT, 0, 4, 0);
    img[7]    = enc_r(OP_HLT, 0, 0, 0);
    img['h30] = 16'hABCD;
    run_prog(mk_exp("st_ld", 16'hABCD, 1'b0, 4, 16'hABCD, 8'd8, 36));
    chk("st_ld/mem20", 32'(dut.mem_q['h20]), 32'h0000ABCD);

    // Countdown loop: three BNZ iterations, r4 counts them
    clear_img();
    img[0] = enc_i(OP_LDI, 1, 3);
    img[1] = enc_i(OP_LDI, 2, 1);
    img[2] = enc_i(OP_LDI, 4, 0);
    img[3] = enc_r(OP_ADD, 4, 4, 2);
    img[4] = enc_r(OP_SUB, 1, 1, 2);
    img[5] = enc_i(OP_BNZ, 0, 3);
    img[6] = enc_r(OP_OUT, 0, 4, 0);
    img[7] = enc_r(OP_HLT, 0, 0, 0);
    run_prog(mk_exp("loop3", 16'h0003, 1'b1, 4, 16'h0003, 8'd8, 58));

    // Unconditional jump skips the fall-through path
    clear_img();
    img[0]  = enc_i(OP_JMP, 0, 8);
    img[1]  = enc_i(OP_LDI, 7, 'hEE);
    img[2]  = enc_r(OP_OUT, 0, 7, 0);
    img[3]  = enc_r(OP_HLT, 0, 0, 0);
    img[8]  = enc_i(OP_LDI, 7, 'h55);
    img[9]  = enc_r(OP_OUT, 0, 7, 0);
    img[10] = enc_r(OP_HLT, 0, 0, 0);
    run_prog(mk_exp("jmp", 16'h0055, 1'b0, 7, 16'h0055, 8'd11, 18));

    // PC wraps from 0xFF to 0x00
    clear_img();
    img[0]    = enc_i(OP_BNZ, 0, 'hFD);
    img[1]    = enc_r(OP_HLT, 0, 0, 0);
    img['hFD] = enc_r(OP_SUB, 3, 1, 1);
    img['hFE] = enc_i(OP_LDI, 7, 'h99);
    img['hFF] = enc_r(OP_OUT, 0, 7, 0);
    run_prog(mk_exp("pc_wrap", 16'h0099, 1'b1, 7, 16'h0099, 8'd2, 26));

    // Reset on the ADD execute edge must not write r3
    clear_img();
    img[0] = enc_i(OP_LDI, 3, 'h11);
    img[1] = enc_r(OP_HLT, 0, 0, 0);
    run_prog(mk_exp("preset_r3", 16'h0000, 1'b0, 3, 16'h0011, 8'd2, 10));
    clear_img();
    img[0] = enc_i(OP_LDI, 1, 5);
    img[1] = enc_i(OP_LDI, 2, 3);
    img[2] = enc_r(OP_ADD, 3, 1, 2);
    img[3] = enc_r(OP_OUT, 0, 3, 0);
    img[4] = enc_r(OP_HLT, 0, 0, 0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    load_img();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (13) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("abort/r3_unchanged", 32'(dut.rf_q[3]), 32'h00000011);
    chk("abort/pc", 32'(dut.pc_q), 32'd0);
    chk("abort/ready", 32'(Ready), 32'd0);
    run_prog(mk_exp("abort_rerun", 16'h0008, 1'b0, 3, 16'h0008, 8'd5, 22));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
